// File: rtl/reg_pipeline.sv
// reg_pipeline: a chain of DEPTH register stages with valid/ready handshaking,
// bubble collapse, flush and an occupancy count.
//
// Ports
//   clk      in   rising-edge clock for all state
//   reset    in   synchronous, active-high reset (clears every valid bit)
//   d        in   upstream data, WIDTH bits
//   d_valid  in   upstream data valid
//   d_ready  out  stage 0 can take d this cycle (combinational from q_ready/flush)
//   q        out  data held in the last stage (registered)
//   q_valid  out  last stage holds valid data (registered)
//   q_ready  in   downstream accepts q this cycle
//   flush    in   drop every held entry on this edge
//   count    out  number of stages holding valid data (registered)
//
// Build option
//   REG_PIPELINE_RESET_DATA_EN  when defined, reset also loads RESET_VAL into
//                               every data register; otherwise data registers
//                               have no reset.
module reg_pipeline #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic                         d_ready,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  input  logic                         q_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] data_en;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             in_xfer;

  // Advance chain: a stage moves when it is empty or the stage after it moves.
  // Running carry keeps the chain out of a self-referencing vector.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = ~valid_q[DEPTH-1] | q_ready;
    adv[DEPTH-1] = carry;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      carry  = ~valid_q[i] | carry;
      adv[i] = carry;
    end
  end

  // Input handshake; flush blocks acceptance so nothing lands in a flushed pipe.
  assign d_ready = adv[0] & ~flush;
  assign in_xfer = d_valid & d_ready;

  // Next valid bits.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
        if (adv[i]) valid_d[i] = valid_q[i-1];
      end
      if (adv[0]) valid_d[0] = in_xfer;
    end
  end

  // Data only moves when real data arrives, so bubbles never overwrite it and
  // a flush leaves every data register untouched.
  always_comb begin
    data_en = '0;
    if (!flush) begin
      data_en[0] = in_xfer;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_en[i] = adv[i] & valid_q[i-1];
      end
    end
  end

  // Occupancy of the next state, registered alongside the valid bits.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // Valid bits and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Data registers.
`ifdef REG_PIPELINE_RESET_DATA_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      if (data_en[0]) data_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (data_en[i]) data_q[i] <= data_q[i-1];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (data_en[0]) data_q[0] <= d;
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (data_en[i]) data_q[i] <= data_q[i-1];
    end
  end
`endif

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign count   = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed self-checking bench for reg_pipeline: a DEPTH=4 instance for most
// scenarios and a DEPTH=1 instance streamed alongside it.
module tb_reg_pipeline;

  localparam logic [7:0] RST_VAL = 8'h5A;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       flush;
  logic [2:0] count;

  logic [7:0] d1;
  logic       d1_valid;
  logic       d1_ready;
  logic [7:0] q1;
  logic       q1_valid;
  logic       q1_ready;
  logic [0:0] count1;

  always #5 clk = ~clk;

  reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RST_VAL)) u_dut (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .flush(flush), .count(count)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RST_VAL)) u_dut1 (
    .clk(clk), .reset(reset), .d(d1), .d_valid(d1_valid), .d_ready(d1_ready),
    .q(q1), .q_valid(q1_valid), .q_ready(q1_ready), .flush(1'b0), .count(count1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [7:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called right after driving inputs at a negedge: records the transfers
  // that the coming posedge will perform and checks output order.
  task automatic observe();
    #1;
    if (d_valid && d_ready) sb.push_back(d);
    if (q_valid && q_ready) begin
      n_out++;
      if (sb.size() == 0) check_eq("spurious_out", 32'(q), 32'hFFFF_FFFF);
      else check_eq("order", 32'(q), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int base;
    int acc;
    int del;

    // Reset with d_valid high: nothing captured.
    reset = 1'b1; d_valid = 1'b1; d = 8'h77; q_ready = 1'b0; flush = 1'b0;
    d1 = 8'h00; d1_valid = 1'b0; q1_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_qvalid", 32'(q_valid), 32'd0);
`ifdef REG_PIPELINE_RESET_DATA_EN
    check_eq("rst_q", 32'(q), 32'(RST_VAL));
`endif
    reset = 1'b0; d_valid = 1'b0;
    #1 check_eq("rst_dready", 32'(d_ready), 32'd1);
    @(negedge clk);
    check_eq("rst_count2", 32'(count), 32'd0);

    // Stream 0x01..0x10 with q_ready=1 into both depths.
    q_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      check_eq("str_qvalid", 32'(q_valid), 32'(c >= 4 && c <= 19));
      if (c >= 4 && c <= 19) check_eq("str_q", 32'(q), 32'(c - 3));
      acc = (c < 16) ? c : 16;
      del = (c < 4) ? 0 : ((c - 4 > 16) ? 16 : c - 4);
      check_eq("str_count", 32'(count), 32'(acc - del));
      check_eq("d1_qvalid", 32'(q1_valid), 32'(c >= 1 && c <= 16));
      if (c >= 1 && c <= 16) check_eq("d1_q", 32'(q1), 32'(c));
      d_valid = (c < 16); d = 8'(c + 1);
      d1_valid = (c < 16); d1 = 8'(c + 1);
      observe();
      if (c < 16) begin
        check_eq("str_dready", 32'(d_ready), 32'd1);
        check_eq("d1_dready", 32'(d1_ready), 32'd1);
      end
    end

    // Backpressure: only 0xA0..0xA3 fit, then release.
    q_ready = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      d_valid = 1'b1; d = 8'hA0 + 8'(idx);
      observe();
      check_eq("bp_dready", 32'(d_ready), 32'(c < 4));
      if (d_ready) idx++;
    end
    @(negedge clk);
    check_eq("bp_count", 32'(count), 32'd4);
    check_eq("bp_qvalid", 32'(q_valid), 32'd1);
    check_eq("bp_q", 32'(q), 32'hA0);
    q_ready = 1'b1; base = n_out;
    for (int c = 0; c < 30 && (n_out - base) < 6; c++) begin
      if (c > 0) @(negedge clk);
      d_valid = (idx < 6); d = 8'hA0 + 8'(idx);
      observe();
      if (d_valid && d_ready) idx++;
    end
    check_eq("bp_delivered", 32'(n_out - base), 32'd6);
    @(negedge clk);
    d_valid = 1'b0;
    check_eq("bp_drain_count", 32'(count), 32'd0);
    check_eq("bp_drain_qvalid", 32'(q_valid), 32'd0);

    // Bubble collapse with q_ready=0.
    q_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      d_valid = (c == 0 || c == 3); d = (c == 3) ? 8'h22 : 8'h11;
      observe();
      if (d_valid) check_eq("bub_dready", 32'(d_ready), 32'd1);
    end
    @(negedge clk);
    d_valid = 1'b0;
    check_eq("bub_count", 32'(count), 32'd2);
    check_eq("bub_qvalid", 32'(q_valid), 32'd1);
    check_eq("bub_q", 32'(q), 32'h11);
    check_eq("bub_stages", 32'(u_dut.valid_q), 32'h0000_000C);

    // Third entry, then flush.
    d_valid = 1'b1; d = 8'h33;
    observe();
    check_eq("fl_dready_pre", 32'(d_ready), 32'd1);
    @(negedge clk);
    check_eq("fl_count_pre", 32'(count), 32'd3);
    flush = 1'b1; d_valid = 1'b1; d = 8'h44;
    observe();
    check_eq("fl_dready", 32'(d_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; d_valid = 1'b0;
    sb.delete();
    check_eq("fl_count", 32'(count), 32'd0);
    check_eq("fl_qvalid", 32'(q_valid), 32'd0);
    check_eq("fl_q_held", 32'(q), 32'h11);

    // Fill, then simultaneous in/out on a full pipe for 20 cycles.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      d_valid = 1'b1; d = 8'hB0 + 8'(c);
      observe();
      check_eq("fill_dready", 32'(d_ready), 32'd1);
    end
    @(negedge clk);
    check_eq("fill_count", 32'(count), 32'd4);
    q_ready = 1'b1; base = n_out;
    for (int c = 0; c < 20; c++) begin
      d_valid = 1'b1; d = 8'hB4 + 8'(c);
      observe();
      check_eq("full_dready", 32'(d_ready), 32'd1);
      @(negedge clk);
      check_eq("full_count", 32'(count), 32'd4);
    end
    check_eq("full_xfers", 32'(n_out - base), 32'd20);

    // Reset mid-operation, together with flush and d_valid.
    reset = 1'b1; flush = 1'b1; d_valid = 1'b1; d = 8'hEE;
    #1;
    check_eq("rst2_hold_qvalid", 32'(q_valid), 32'd1);
    check_eq("rst2_hold_count", 32'(count), 32'd4);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; d_valid = 1'b0;
    sb.delete();
    check_eq("rst2_count", 32'(count), 32'd0);
    check_eq("rst2_qvalid", 32'(q_valid), 32'd0);
`ifdef REG_PIPELINE_RESET_DATA_EN
    check_eq("rst2_q", 32'(q), 32'(RST_VAL));
`endif
    #1 check_eq("rst2_dready", 32'(d_ready), 32'd1);
    @(negedge clk);
    check_eq("rst2_count_after", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage; SHALL be 1 or greater.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be 1 or greater.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into the data registers at reset when REG_PIPELINE_RESET_DATA_EN is defined.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 d  input  WIDTH  upstream data.
REQ-007 d_valid  input  1  upstream data valid.
REQ-008 d_ready  output  1  block can accept d this cycle.
REQ-009 q  output  WIDTH  data of the last stage.
REQ-010 q_valid  output  1  last stage holds valid data.
REQ-011 q_ready  input  1  downstream accepts q this cycle.
REQ-012 flush  input  1  discards all held data.
REQ-013 count  output  $clog2(DEPTH+1)  number of stages holding valid data.

Function
REQ-014 The block SHALL be a chain of DEPTH stages, each with one WIDTH-bit data register and one valid bit; stage 0 is the input stage and stage DEPTH-1 drives q/q_valid.
REQ-015 Input transfer SHALL occur on a rising edge where d_valid=1 and d_ready=1; output transfer SHALL occur where q_valid=1 and q_ready=1.
REQ-016 Stage DEPTH-1 advances when it is empty or an output transfer occurs; stage i<DEPTH-1 advances when it is empty or stage i+1 advances.
REQ-017 d_ready SHALL be 1 when stage 0 advances and flush=0; otherwise 0. d_ready may depend combinationally on q_ready.
REQ-018 An advancing stage SHALL load the data and valid bit of the stage before it (stage 0 loads d and the input-transfer condition); a non-advancing stage SHALL hold its data and valid bit.
REQ-019 Bubbles SHALL collapse: an empty stage SHALL accept data even if downstream stages are stalled.
REQ-020 Latency SHALL be DEPTH cycles: data accepted at edge N appears on q with q_valid=1 after edge N+DEPTH-1, when q_ready stays 1 and the pipe starts empty.
REQ-021 Throughput SHALL be one transfer per cycle when q_ready=1 continuously.
REQ-022 With q_ready=0, the pipe SHALL fill until all DEPTH stages are valid, then hold d_ready=0. No data SHALL be lost, duplicated or reordered.
REQ-023 Full pipe with simultaneous input and output transfer in the same cycle: both SHALL complete, and count SHALL stay DEPTH.
REQ-024 q and q_valid SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from d.
REQ-025 Flush: on an edge with flush=1, all valid bits SHALL clear and count SHALL become 0; data registers hold their values. An output transfer in the flush cycle counts as delivered.
REQ-026 count SHALL equal the number of set valid bits after every edge.
REQ-027 DEPTH=1 SHALL behave as a single full-throughput register slice.

Reset
REQ-028 On an edge with reset=1, all valid bits SHALL be cleared, so q_valid=0, count=0 and d_ready=1 in the cycle after reset.
REQ-029 reset SHALL take priority over flush and over any transfer in the same cycle. Data in flight mid-operation is discarded.
REQ-030 Asserting reset SHALL not affect outputs until the next rising clk edge.

Configuration
REQ-031 Macro REG_PIPELINE_RESET_DATA_EN defined: reset SHALL also load RESET_VAL into every stage data register, so q=RESET_VAL after reset.
REQ-032 Macro REG_PIPELINE_RESET_DATA_EN undefined: data registers SHALL have no reset (q is undefined until the first data arrives). Valid-bit behaviour is identical in both cases.

Verification
REQ-033 Stream, WIDTH=8, DEPTH=4, q_ready=1: send 0x01..0x10 back-to-back -> q_valid first high 4 edges after first accept; q=0x01..0x10 in order on consecutive cycles; d_ready never low.
REQ-034 Backpressure: q_ready=0, d_valid=1 with 0xA0..0xA5 -> accepts 0xA0..0xA3, then d_ready=0 and count=4; raise q_ready -> outputs 0xA0..0xA5 in order, none lost.
REQ-035 Bubble collapse: accept 0x11, idle 2 cycles, accept 0x22, with q_ready=0 -> count=2 and the two entries sit in the last two stages; q=0x11.
REQ-036 Flush and reset: pipe holds 3 entries, pulse flush -> count=0, q_valid=0 next cycle. Reset asserted together with d_valid=1 -> count=0 and the input is not captured. With REG_PIPELINE_RESET_DATA_EN and RESET_VAL=0x5A -> q=0x5A.
REQ-037 Full pipe, q_ready=1, d_valid=1 for 20 cycles -> count stays 4 and one transfer occurs per cycle. Repeat the stream test with DEPTH=1 -> latency 1, full throughput.
